tie_lookup_pipe: RTL
====================

Name: tie_lookup_pipe

Overview:
- Parametrised TIE lookup device that replaces the fixed single-table lookup attached to an Xtensa core's TIE lookup interface.
- The core issues an address with a request strobe. The block returns table data a configurable number of cycles later, and deasserts ready to stall the core.
- Adds a register-file table with a side write port for runtime loading, configurable latency, and out-of-range detection.

Parameters:
- ADDR_W, 8, width of TIE_lut_Out (lookup address)
- DATA_W, 32, width of TIE_lut_In and table entries
- DEPTH, 256, number of table entries; 1 <= DEPTH <= 2**ADDR_W
- LATENCY, 1, cycles from accepted request edge to valid TIE_lut_In; legal range 1..4

Ports:
- CLK  in  1  core clock; all state changes on the rising edge
- BReset  in  1  asynchronous, active-high reset
- TIE_lut_Out_Req  in  1  lookup request from core
- TIE_lut_Out  in  ADDR_W  lookup address from core
- TIE_lut_Rdy  out  1  device can accept a request this cycle
- TIE_lut_In  out  DATA_W  lookup result to core
- TblWrEn  in  1  table write strobe (loader side)
- TblWrAddr  in  ADDR_W  table write address
- TblWrData  in  DATA_W  table write data
- OobErr  out  1  one-cycle pulse: an out-of-range lookup reached the output

Behaviour:
- Reset: BReset is asynchronous and active-high. While it is asserted:
  - All table entries, pipeline data and valid flags clear to 0.
  - TIE_lut_In = 0, OobErr = 0, TIE_lut_Rdy = 0.
  - TIE_lut_Rdy rises on the first CLK edge after BReset deasserts (registered ready-enable flop).
- Accept: a request is accepted at a rising edge where TIE_lut_Out_Req=1 and TIE_lut_Rdy=1.
  - A request with Rdy=0 is ignored. The core holds or retries it; the block never queues it.
- Ready: TIE_lut_Rdy = ready-enable flop AND NOT TblWrEn.
  - The write port has priority and stalls lookups in the same cycle.
  - No other stall source exists. Back-to-back accepts every cycle are supported (full throughput).
- Read point: the table is read with TIE_lut_Out at the accept edge.
- Pipeline: LATENCY stages, each holding a data word, a valid bit and an oob bit.
  - TIE_lut_In is the last-stage data register, updated only when the last stage's valid bit is 1.
  - Otherwise TIE_lut_In holds its previous value.
  - The result is valid on TIE_lut_In exactly LATENCY cycles after the accept edge.
- Out of range: an address >= DEPTH returns all-zero data. OobErr pulses high for one cycle, coincident with that result becoming valid.
- Write: at an edge with TblWrEn=1, if TblWrAddr < DEPTH, the entry is updated with TblWrData. An out-of-range write is silently dropped.
- Hazard: no lookup can be accepted in the same cycle as a write (Rdy=0). A lookup accepted at edge N followed by a write to the same entry at edge N+1 returns the old value.
- Reset mid-operation: in-flight results are discarded. No stale data appears after reset; TIE_lut_In stays 0 until the first new result.
- Elaboration: LATENCY outside 1..4, or DEPTH > 2**ADDR_W, triggers an elaboration error via a generate-time check.

Optional Feature:
- Macro: TIE_LOOKUP_PARITY_EN
- Defined:
  - Each entry stores an extra even-parity bit, computed over TblWrData at write time.
  - Parity is recomputed on read and carried down the pipeline.
  - Output port ParErr (1 bit) pulses for one cycle, coincident with the result, when stored and recomputed parity differ.
  - Returned data is not altered.
  - Out-of-range lookups never flag ParErr.
  - Stored parity bits reset to 0, consistent with zeroed entries.
- Undefined: no parity storage, no ParErr port. Behaviour is otherwise identical.

Test Plan:
- Reset then idle: BReset high 3 cycles -> TIE_lut_In=0, TIE_lut_Rdy=0; Rdy=1 one edge after release.
- Load/lookup: write 0xDEADBEEF to addr 0x05, then request addr 0x05 with LATENCY=2 -> TIE_lut_In=0xDEADBEEF exactly 2 cycles after the accept edge; OobErr=0.
- Streaming: write addrs 0..3 with 0x10,0x20,0x30,0x40; request 0,1,2,3 on consecutive cycles -> outputs 0x10,0x20,0x30,0x40 on consecutive cycles, Rdy held at 1.
- Write stall: assert TblWrEn (addr 0x07, 0x55) in the same cycle as a request for 0x07 -> Rdy=0, request not accepted; retry next cycle -> returns 0x55.
- Out of range: DEPTH=200, request addr 0xF0 -> TIE_lut_In=0 and OobErr one-cycle pulse after LATENCY; write to 0xF0 has no effect.
- Reset mid-flight: LATENCY=4, accept a lookup of 0xDEADBEEF, assert BReset 2 cycles later -> TIE_lut_In stays 0, no late result or OobErr after release.

Source files
------------

// File: rtl/tie_lookup_pipe_if.sv
// Core-side TIE lookup bus plus the table loader port of tie_lookup_pipe.
// ParErr is present only when TIE_LOOKUP_PARITY_EN is defined.
interface tie_lookup_pipe_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              TIE_lut_Out_Req;
  logic [ADDR_W-1:0] TIE_lut_Out;
  logic              TIE_lut_Rdy;
  logic [DATA_W-1:0] TIE_lut_In;
  logic              TblWrEn;
  logic [ADDR_W-1:0] TblWrAddr;
  logic [DATA_W-1:0] TblWrData;
  logic              OobErr;
`ifdef TIE_LOOKUP_PARITY_EN
  logic              ParErr;

  modport master (
    output TIE_lut_Out_Req, TIE_lut_Out, TblWrEn, TblWrAddr, TblWrData,
    input  TIE_lut_Rdy, TIE_lut_In, OobErr, ParErr
  );
  modport slave (
    input  TIE_lut_Out_Req, TIE_lut_Out, TblWrEn, TblWrAddr, TblWrData,
    output TIE_lut_Rdy, TIE_lut_In, OobErr, ParErr
  );
`else
  modport master (
    output TIE_lut_Out_Req, TIE_lut_Out, TblWrEn, TblWrAddr, TblWrData,
    input  TIE_lut_Rdy, TIE_lut_In, OobErr
  );
  modport slave (
    input  TIE_lut_Out_Req, TIE_lut_Out, TblWrEn, TblWrAddr, TblWrData,
    output TIE_lut_Rdy, TIE_lut_In, OobErr
  );
`endif
endinterface

// File: rtl/tie_lookup_pipe.sv
// Parametrised TIE lookup table with a runtime write port, LATENCY-stage result
// pipeline and out-of-range flagging. Define TIE_LOOKUP_PARITY_EN for per-entry parity.
module tie_lookup_pipe #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic             CLK,
  input  logic             BReset,
  tie_lookup_pipe_if.slave lut
);
  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("tie_lookup_pipe: LATENCY=%0d is outside 1..4", LATENCY);
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("tie_lookup_pipe: DEPTH=%0d does not fit ADDR_W=%0d", DEPTH, ADDR_W);
  end

  logic              rdy_en;
  logic              accept;
  logic              rd_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              rq_v;
  logic              rq_oob;
  logic [IDX_W-1:0]  rq_idx;
  logic [DATA_W-1:0] rd_data;

  logic [LATENCY-1:0] in_v, in_o, st_v, st_o;
  logic [DATA_W-1:0]  in_d [LATENCY];
  logic [DATA_W-1:0]  st_d [LATENCY];

`ifdef TIE_LOOKUP_PARITY_EN
  logic               mem_par [DEPTH];
  logic               rd_perr;
  logic [LATENCY-1:0] in_p, st_p;
`endif

  assign rd_idx      = lut.TIE_lut_Out[IDX_W-1:0];
  assign wr_idx      = lut.TblWrAddr[IDX_W-1:0];
  assign rd_in_range = {1'b0, lut.TIE_lut_Out} < DEPTH_LIM;
  assign wr_in_range = {1'b0, lut.TblWrAddr} < DEPTH_LIM;

  // The loader always wins: a write cycle stalls the core for that cycle.
  assign lut.TIE_lut_Rdy = rdy_en & ~lut.TblWrEn;
  assign accept          = lut.TIE_lut_Out_Req & lut.TIE_lut_Rdy;

  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // NOTE: entries must read back as zero after reset, so the table is built
  // from resettable flops rather than left to an uninitialised RAM.
  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
`ifdef TIE_LOOKUP_PARITY_EN
        mem_par[i] <= 1'b0;
`endif
      end
    end else if (lut.TblWrEn && wr_in_range) begin
      mem[wr_idx] <= lut.TblWrData;
`ifdef TIE_LOOKUP_PARITY_EN
      mem_par[wr_idx] <= ^lut.TblWrData;
`endif
    end
  end

  // NOTE: non-blocking updates make the table read from the request register
  // see pre-edge contents, so a write one edge after an accept returns old data.
  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      rq_v   <= 1'b0;
      rq_oob <= 1'b0;
      rq_idx <= '0;
    end else begin
      rq_v   <= accept;
      rq_oob <= accept & ~rd_in_range;
      if (accept) rq_idx <= rd_in_range ? rd_idx : '0;
    end
  end

  assign rd_data = rq_oob ? '0 : mem[rq_idx];
`ifdef TIE_LOOKUP_PARITY_EN
  assign rd_perr = ~rq_oob & ((^mem[rq_idx]) ^ mem_par[rq_idx]);
`endif

  assign in_v[0] = rq_v;
  assign in_o[0] = rq_oob;
  assign in_d[0] = rd_data;
`ifdef TIE_LOOKUP_PARITY_EN
  assign in_p[0] = rd_perr;
`endif
  for (genvar g = 1; g < LATENCY; g++) begin : g_stage_link
    assign in_v[g] = st_v[g-1];
    assign in_o[g] = st_o[g-1];
    assign in_d[g] = st_d[g-1];
`ifdef TIE_LOOKUP_PARITY_EN
    assign in_p[g] = st_p[g-1];
`endif
  end

  // Data registers load only with a valid word, so the output holds between results.
  always_ff @(posedge CLK or posedge BReset) begin
    if (BReset) begin
      st_v <= '0;
      st_o <= '0;
`ifdef TIE_LOOKUP_PARITY_EN
      st_p <= '0;
`endif
      for (int i = 0; i < LATENCY; i++) st_d[i] <= '0;
    end else begin
      st_v <= in_v;
      st_o <= in_o & in_v;
`ifdef TIE_LOOKUP_PARITY_EN
      st_p <= in_p & in_v;
`endif
      for (int i = 0; i < LATENCY; i++) begin
        if (in_v[i]) st_d[i] <= in_d[i];
      end
    end
  end

  assign lut.TIE_lut_In = st_d[LATENCY-1];
  assign lut.OobErr     = st_v[LATENCY-1] & st_o[LATENCY-1];
`ifdef TIE_LOOKUP_PARITY_EN
  assign lut.ParErr     = st_v[LATENCY-1] & st_p[LATENCY-1];
`endif

endmodule
